uart_rx_param: RTL and testbench

Parametrised UART receiver with configurable frame format (data bits, parity, stop bits), oversampled start-bit qualification, sticky error flags and a small show-ahead receive FIFO. It sits between the pad-side serial input and the consuming logic, driven by the shared baud-rate tick generator. It supersedes the fixed 8N1 receiver: consumers pop bytes at their own pace instead of catching a single-cycle done strobe.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_fifo.sv | 60 ++++++
 rtl/uart_rx_param.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_param.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity mode encodings and a
// constant-foldable ceil(log2) helper also used by the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Smallest w with 2**w >= value; usable in parameter and port declarations.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small show-ahead FIFO for received characters. The head entry is always
// visible on o_rdata; a pop that arrives while full frees room for a push in
// the same cycle, and a pop while empty is ignored.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_wr,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_rd,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [clog2(DEPTH):0]  o_level
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == C_DEPTH);
  assign w_pop   = i_rd && !o_empty;
  assign w_push  = i_wr && (!o_full || w_pop);
  assign o_level = r_level;
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage array; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two; level tracks occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised line input, oversampled start-bit
// qualification, mid-bit sampling of data/parity/stop, sticky error flags and
// a show-ahead receive FIFO that only ever holds good frames.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_baud_tick,
  input  logic                        i_rx,
  input  logic                        i_rd,
  input  logic                        i_clr_err,
  output logic [DATA_BITS-1:0]        o_data,
  output logic                        o_valid,
  output logic                        o_rx_done,
  output logic                        o_frame_err,
  output logic                        o_parity_err,
  output logic                        o_overrun,
  output logic [clog2(FIFO_DEPTH):0]  o_level
);

  localparam int TW = clog2(OVERSAMPLE);
  localparam logic [TW-1:0] C_HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] C_FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    C_DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    C_STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic          C_PAR_MODE  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  logic                 r_rx_meta;
  logic                 r_rx_s;
  rx_state_e            r_state;
  rx_state_e            w_next_state;
  logic [TW-1:0]        r_tick_cnt;
  logic [2:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err;
  logic                 r_frame_err;
  logic                 r_parity_err;
  logic                 r_overrun;
  logic                 r_rx_done;

  logic w_half_hit;
  logic w_mid_hit;
  logic w_counting;
  logic w_sample_data;
  logic w_sample_parity;
  logic w_sample_stop;
  logic w_frame_set;
  logic w_frame_end;
  logic w_parity_set;
  logic w_push;
  logic w_overrun_set;
  logic w_fifo_empty;
  logic w_fifo_full;
  logic w_exp_parity;

  assign w_half_hit    = i_baud_tick && (r_tick_cnt == C_HALF_LAST);
  assign w_mid_hit     = i_baud_tick && (r_tick_cnt == C_FULL_LAST);
  assign w_exp_parity  = (^r_shift) ^ C_PAR_MODE;
  assign w_frame_set   = w_sample_stop && !r_rx_s;
  assign w_frame_end   = w_sample_stop && r_rx_s && (r_bit_cnt == C_STOP_LAST);
  assign w_parity_set  = w_frame_end && r_par_err;
  assign w_push        = w_frame_end && !r_par_err;
  assign w_overrun_set = w_push && w_fifo_full && !i_rd;

  // Two-flop synchroniser for the asynchronous line, idling high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  // FSM next-state logic: start qualification at half a bit, then one sample per bit.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (!r_rx_s) w_next_state = ST_START;
      ST_START:  if (w_half_hit) w_next_state = r_rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:   if (w_mid_hit && (r_bit_cnt == C_DATA_LAST))
                   w_next_state = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_mid_hit) w_next_state = ST_STOP;
      ST_STOP:   if (w_mid_hit) begin
                   if (!r_rx_s)                        w_next_state = ST_BREAK;
                   else if (r_bit_cnt == C_STOP_LAST)  w_next_state = ST_IDLE;
                 end
      ST_BREAK:  if (r_rx_s) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: which counter runs and which kind of bit is being sampled.
  always_comb begin
    w_counting      = 1'b0;
    w_sample_data   = 1'b0;
    w_sample_parity = 1'b0;
    w_sample_stop   = 1'b0;
    case (r_state)
      ST_START:  w_counting = 1'b1;
      ST_DATA:   begin w_counting = 1'b1; w_sample_data   = w_mid_hit; end
      ST_PARITY: begin w_counting = 1'b1; w_sample_parity = w_mid_hit; end
      ST_STOP:   begin w_counting = 1'b1; w_sample_stop   = w_mid_hit; end
      default:   w_counting = 1'b0;
    endcase
  end

  // Tick and bit counters restart on every state change so each phase counts from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (r_state != w_next_state) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
    end else begin
      if (w_counting && i_baud_tick)
        r_tick_cnt <= (r_tick_cnt == C_FULL_LAST) ? '0 : r_tick_cnt + 1'b1;
      if (w_sample_data || w_sample_stop)
        r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  // Data shifts in LSB first; the parity verdict is held until the stop bits are done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift   <= '0;
      r_par_err <= 1'b0;
    end else begin
      if (w_sample_data)
        r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
      if (r_state == ST_START)
        r_par_err <= 1'b0;
      else if (w_sample_parity)
        r_par_err <= (r_rx_s != w_exp_parity);
    end
  end

  // Sticky error flags (a new error beats a clear in the same cycle) and the done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
      r_rx_done    <= 1'b0;
    end else begin
      if (w_frame_set)        r_frame_err  <= 1'b1;
      else if (i_clr_err)     r_frame_err  <= 1'b0;
      if (w_parity_set)       r_parity_err <= 1'b1;
      else if (i_clr_err)     r_parity_err <= 1'b0;
      if (w_overrun_set)      r_overrun    <= 1'b1;
      else if (i_clr_err)     r_overrun    <= 1'b0;
      r_rx_done <= w_push && !w_overrun_set;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (w_push),
    .i_wdata (r_shift),
    .i_rd    (i_rd),
    .o_rdata (o_data),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_level (o_level)
  );

  assign o_valid      = !w_fifo_empty;
  assign o_rx_done    = r_rx_done;
  assign o_frame_err  = r_frame_err;
  assign o_parity_err = r_parity_err;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param: three receivers (8N1, 7E1, 8N2) share clock,
// reset and a baud tick that fires every clock, so one bit lasts 16 clocks.
module tb_uart_rx_param;

  localparam int BIT_CLKS = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick;

  logic rx8n1 = 1'b1, rd8n1 = 1'b0, clr8n1 = 1'b0;
  logic rx7e1 = 1'b1, rd7e1 = 1'b0, clr7e1 = 1'b0;
  logic rx8n2 = 1'b1, rd8n2 = 1'b0, clr8n2 = 1'b0;

  logic [7:0] data8n1, data8n2;
  logic [6:0] data7e1;
  logic [2:0] level8n1, level7e1, level8n2;
  logic valid8n1, done8n1, ferr8n1, perr8n1, ovr8n1;
  logic valid7e1, done7e1, ferr7e1, perr7e1, ovr7e1;
  logic valid8n2, done8n2, ferr8n2, perr8n2, ovr8n2;

  int compared   = 0;
  int mismatched = 0;
  int doneCnt8n1 = 0;
  int doneCnt7e1 = 0;
  int doneCnt8n2 = 0;

  typedef struct {
    bit         preClr;
    int         drainCount;
    logic [7:0] drainFirst;
    logic [7:0] txData;
    bit         popAtStop;
    int         expLevel;
    logic [7:0] expHead;
    bit         expOverrun;
    int         expDone;
  } vec_t;

  vec_t vecs[11];

  // Free-running clock; the baud tick is permanently asserted.
  always #5 clk = ~clk;
  assign tick = 1'b1;

  uart_rx_param #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1),
                  .OVERSAMPLE(16), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .rst(rst), .i_baud_tick(tick), .i_rx(rx8n1), .i_rd(rd8n1),
    .i_clr_err(clr8n1), .o_data(data8n1), .o_valid(valid8n1), .o_rx_done(done8n1),
    .o_frame_err(ferr8n1), .o_parity_err(perr8n1), .o_overrun(ovr8n1), .o_level(level8n1));

  uart_rx_param #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1),
                  .OVERSAMPLE(16), .FIFO_DEPTH(4)) u_7e1 (
    .clk(clk), .rst(rst), .i_baud_tick(tick), .i_rx(rx7e1), .i_rd(rd7e1),
    .i_clr_err(clr7e1), .o_data(data7e1), .o_valid(valid7e1), .o_rx_done(done7e1),
    .o_frame_err(ferr7e1), .o_parity_err(perr7e1), .o_overrun(ovr7e1), .o_level(level7e1));

  uart_rx_param #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2),
                  .OVERSAMPLE(16), .FIFO_DEPTH(4)) u_8n2 (
    .clk(clk), .rst(rst), .i_baud_tick(tick), .i_rx(rx8n2), .i_rd(rd8n2),
    .i_clr_err(clr8n2), .o_data(data8n2), .o_valid(valid8n2), .o_rx_done(done8n2),
    .o_frame_err(ferr8n2), .o_parity_err(perr8n2), .o_overrun(ovr8n2), .o_level(level8n2));

  // Count o_rx_done pulses per receiver, sampled mid-cycle.
  always @(negedge clk) begin
    if (done8n1) doneCnt8n1++;
    if (done7e1) doneCnt7e1++;
    if (done8n2) doneCnt8n2++;
  end

  // Frame images with the start bit in bit 0, transmitted LSB first.
  function automatic logic [15:0] frame8(input logic [7:0] d, input logic stop2);
    return {5'b0, stop2, 1'b1, d, 1'b0};
  endfunction

  function automatic logic [15:0] frame7(input logic [6:0] d, input logic par);
    return {6'b0, 1'b1, par, d, 1'b0};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic setRx(input int which, input logic v);
    case (which)
      0:       rx8n1 = v;
      1:       rx7e1 = v;
      default: rx8n2 = v;
    endcase
  endtask

  task automatic setRd(input int which, input logic v);
    case (which)
      0:       rd8n1 = v;
      1:       rd7e1 = v;
      default: rd8n2 = v;
    endcase
  endtask

  // Drive one frame starting at a falling clock edge; optionally pop exactly on
  // the cycle the final stop bit is sampled (10 clocks into that bit).
  task automatic applyStimulus(input int which, input logic [15:0] bits, input int nbits,
                               input bit popAtStop);
    for (int b = 0; b < nbits; b++) begin
      setRx(which, bits[b]);
      for (int c = 0; c < BIT_CLKS; c++) begin
        setRd(which, popAtStop && (b == nbits - 1) && (c == 10));
        @(negedge clk);
      end
    end
    setRd(which, 1'b0);
    setRx(which, 1'b1);
  endtask

  task automatic popOne(input int which);
    setRd(which, 1'b1);
    @(negedge clk);
    setRd(which, 1'b0);
  endtask

  task automatic clrErr(input int which);
    case (which)
      0:       clr8n1 = 1'b1;
      1:       clr7e1 = 1'b1;
      default: clr8n2 = 1'b1;
    endcase
    @(negedge clk);
    clr8n1 = 1'b0;
    clr7e1 = 1'b0;
    clr8n2 = 1'b0;
  endtask

  initial begin
    int d0;

    // Overrun scenario on the 8N1 receiver with a 4-deep FIFO.
    vecs[0]  = '{1'b0, 0, 8'h00, 8'h01, 1'b0, 1, 8'h01, 1'b0, 1};
    vecs[1]  = '{1'b0, 0, 8'h00, 8'h02, 1'b0, 2, 8'h01, 1'b0, 1};
    vecs[2]  = '{1'b0, 0, 8'h00, 8'h03, 1'b0, 3, 8'h01, 1'b0, 1};
    vecs[3]  = '{1'b0, 0, 8'h00, 8'h04, 1'b0, 4, 8'h01, 1'b0, 1};
    vecs[4]  = '{1'b0, 0, 8'h00, 8'h05, 1'b0, 4, 8'h01, 1'b1, 0};
    vecs[5]  = '{1'b1, 4, 8'h01, 8'h01, 1'b0, 1, 8'h01, 1'b0, 1};
    vecs[6]  = '{1'b0, 0, 8'h00, 8'h02, 1'b0, 2, 8'h01, 1'b0, 1};
    vecs[7]  = '{1'b0, 0, 8'h00, 8'h03, 1'b0, 3, 8'h01, 1'b0, 1};
    vecs[8]  = '{1'b0, 0, 8'h00, 8'h04, 1'b0, 4, 8'h01, 1'b0, 1};
    vecs[9]  = '{1'b0, 0, 8'h00, 8'h05, 1'b1, 4, 8'h02, 1'b0, 1};
    vecs[10] = '{1'b0, 0, 8'h00, 8'h06, 1'b0, 4, 8'h02, 1'b1, 0};

    // Reset values while reset is held.
    repeat (4) @(negedge clk);
    checkOutput("rst_level", 32'(level8n1), 32'd0);
    checkOutput("rst_valid", 32'(valid8n1), 32'd0);
    checkOutput("rst_data", 32'(data8n1), 32'd0);
    checkOutput("rst_flags", {29'd0, ferr8n1, perr8n1, ovr8n1}, 32'd0);
    checkOutput("rst_done", 32'(done8n1), 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1: two frames, no reads, then one pop.
    d0 = doneCnt8n1;
    applyStimulus(0, frame8(8'hA5, 1'b1), 10, 1'b0);
    applyStimulus(0, frame8(8'h3C, 1'b1), 10, 1'b0);
    checkOutput("8n1_level2", 32'(level8n1), 32'd2);
    checkOutput("8n1_head_a5", 32'(data8n1), 32'hA5);
    checkOutput("8n1_done2", 32'(doneCnt8n1 - d0), 32'd2);
    popOne(0);
    checkOutput("8n1_head_3c", 32'(data8n1), 32'h3C);
    checkOutput("8n1_level1", 32'(level8n1), 32'd1);
    popOne(0);
    checkOutput("8n1_empty", 32'(valid8n1), 32'd0);

    // 7E1: 0x41 has two ones, so even parity is 0; send 1 instead.
    d0 = doneCnt7e1;
    applyStimulus(1, frame7(7'h41, 1'b1), 10, 1'b0);
    checkOutput("7e1_perr", 32'(perr7e1), 32'd1);
    checkOutput("7e1_perr_level", 32'(level7e1), 32'd0);
    checkOutput("7e1_perr_ferr", 32'(ferr7e1), 32'd0);
    checkOutput("7e1_perr_nodone", 32'(doneCnt7e1 - d0), 32'd0);
    clrErr(1);
    checkOutput("7e1_perr_clr", 32'(perr7e1), 32'd0);
    applyStimulus(1, frame7(7'h41, 1'b0), 10, 1'b0);
    checkOutput("7e1_good_level", 32'(level7e1), 32'd1);
    checkOutput("7e1_good_data", 32'(data7e1), 32'h41);
    checkOutput("7e1_good_perr", 32'(perr7e1), 32'd0);

    // Two-clock low glitch on an idle line must be rejected silently.
    d0 = doneCnt7e1;
    rx7e1 = 1'b0;
    repeat (2) @(negedge clk);
    rx7e1 = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    checkOutput("glitch_level", 32'(level7e1), 32'd1);
    checkOutput("glitch_flags", {29'd0, ferr7e1, perr7e1, ovr7e1}, 32'd0);
    checkOutput("glitch_nodone", 32'(doneCnt7e1 - d0), 32'd0);
    popOne(1);
    applyStimulus(1, frame7(7'h2A, 1'b1), 10, 1'b0);
    checkOutput("glitch_next_data", 32'(data7e1), 32'h2A);
    checkOutput("glitch_next_level", 32'(level7e1), 32'd1);

    // 8N2: bad second stop bit, then a long break, then a clean frame.
    applyStimulus(2, frame8(8'h55, 1'b0), 11, 1'b0);
    checkOutput("8n2_ferr", 32'(ferr8n2), 32'd1);
    checkOutput("8n2_ferr_level", 32'(level8n2), 32'd0);
    clrErr(2);
    checkOutput("8n2_ferr_clr", 32'(ferr8n2), 32'd0);
    repeat (4) @(negedge clk);
    rx8n2 = 1'b0;
    repeat (11 * BIT_CLKS * 3 / 2) @(negedge clk);
    checkOutput("break_first_err", 32'(ferr8n2), 32'd1);
    clrErr(2);
    repeat (11 * BIT_CLKS * 3 / 2) @(negedge clk);
    checkOutput("break_single_err", 32'(ferr8n2), 32'd0);
    rx8n2 = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    d0 = doneCnt8n2;
    applyStimulus(2, frame8(8'h12, 1'b1), 11, 1'b0);
    checkOutput("8n2_after_break_data", 32'(data8n2), 32'h12);
    checkOutput("8n2_after_break_level", 32'(level8n2), 32'd1);
    checkOutput("8n2_after_break_done", 32'(doneCnt8n2 - d0), 32'd1);
    checkOutput("8n2_after_break_ferr", 32'(ferr8n2), 32'd0);

    // Table-driven FIFO fill, overrun and push-with-pop on the 8N1 receiver.
    for (int v = 0; v < 11; v++) begin
      if (vecs[v].preClr) clrErr(0);
      for (int k = 0; k < vecs[v].drainCount; k++) begin
        checkOutput($sformatf("vec%0d_drain%0d", v, k), 32'(data8n1),
                    32'(vecs[v].drainFirst + 8'(k)));
        popOne(0);
      end
      if (vecs[v].drainCount > 0)
        checkOutput($sformatf("vec%0d_drained", v), 32'(level8n1), 32'd0);
      d0 = doneCnt8n1;
      applyStimulus(0, frame8(vecs[v].txData, 1'b1), 10, vecs[v].popAtStop);
      checkOutput($sformatf("vec%0d_level", v), 32'(level8n1), 32'(vecs[v].expLevel));
      checkOutput($sformatf("vec%0d_head", v), 32'(data8n1), 32'(vecs[v].expHead));
      checkOutput($sformatf("vec%0d_overrun", v), 32'(ovr8n1), 32'(vecs[v].expOverrun));
      checkOutput($sformatf("vec%0d_done", v), 32'(doneCnt8n1 - d0), 32'(vecs[v].expDone));
    end
    popOne(0);
    checkOutput("post_pop_head3", 32'(data8n1), 32'h03);
    popOne(0);
    checkOutput("post_pop_head4", 32'(data8n1), 32'h04);
    checkOutput("post_pop_level", 32'(level8n1), 32'd2);

    // Reset in the middle of the data bits of 0xFF.
    rx8n1 = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    rx8n1 = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midrst_level", 32'(level8n1), 32'd0);
    checkOutput("midrst_valid", 32'(valid8n1), 32'd0);
    checkOutput("midrst_data", 32'(data8n1), 32'd0);
    checkOutput("midrst_flags", {29'd0, ferr8n1, perr8n1, ovr8n1}, 32'd0);
    rst = 1'b1;
    repeat (12 * BIT_CLKS) @(negedge clk);
    checkOutput("midrst_no_push", 32'(level8n1), 32'd0);
    d0 = doneCnt8n1;
    applyStimulus(0, frame8(8'h81, 1'b1), 10, 1'b0);
    checkOutput("midrst_next_data", 32'(data8n1), 32'h81);
    checkOutput("midrst_next_level", 32'(level8n1), 32'd1);
    checkOutput("midrst_next_done", 32'(doneCnt8n1 - d0), 32'd1);
    checkOutput("midrst_next_flags", {29'd0, ferr8n1, perr8n1, ovr8n1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
